// File: rtl/pwm_duty_slew.sv
// Duty-level control for the LED PWM: cleans up the DIP/mode switches and walks the
// duty one step per timer tick toward the switch setting, or sweeps it in breathe mode.

module pwm_duty_slew_debounce #(
    parameter int WIDTH  = 4,
    parameter int CYCLES = 120000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] debounced
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (sync != cand) begin
            count_next = '0;
        end else if (count != CW'(CYCLES)) begin
            count_next = count + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta      <= '1;
            sync      <= '1;
            cand      <= '1;
            count     <= '0;
            debounced <= '1;
        end else begin
            meta  <= raw;
            sync  <= meta;
            cand  <= sync;
            count <= count_next;
            // The copy lands on the same edge the count reaches its limit.
            if (count_next == CW'(CYCLES)) begin
                debounced <= cand;
            end
        end
    end
endmodule

module pwm_duty_slew #(
    parameter int STEP_CYCLES     = 1200000,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       breathe_n,
    output logic [3:0] duty,
    output logic       step,
    output logic       at_target
);
    localparam int TW = $clog2(STEP_CYCLES);

    typedef enum logic [2:0] {
        HOLD,
        UP,
        DOWN,
        BR_UP,
        BR_DOWN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    duty_next;
    logic [3:0]    sw_deb;
    logic          breathe_n_deb;
    logic [3:0]    target;
    logic          breathe;
    logic [TW-1:0] timer;
    logic          tick;

    pwm_duty_slew_debounce #(.WIDTH(4), .CYCLES(DEBOUNCE_CYCLES)) u_sw_deb (
        .clk       (clk),
        .reset     (reset),
        .raw       (sw),
        .debounced (sw_deb)
    );

    pwm_duty_slew_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_breathe_deb (
        .clk       (clk),
        .reset     (reset),
        .raw       (breathe_n),
        .debounced (breathe_n_deb)
    );

    assign target  = ~sw_deb;
    assign breathe = ~breathe_n_deb;
    assign tick    = (timer == TW'(STEP_CYCLES - 1));

    // Free-running: mode and target changes never re-phase the step grid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_comb begin
        state_next = state;
        duty_next  = duty;
        case (state)
            HOLD: begin
                if (breathe) begin
                    state_next = BR_UP;
                end else if (target > duty) begin
                    state_next = UP;
                end else if (target < duty) begin
                    state_next = DOWN;
                end
            end
            UP, DOWN: begin
                // Direction is re-resolved every cycle, so a crossed target reverses at once.
                if (breathe) begin
                    state_next = BR_UP;
                end else if (target == duty) begin
                    state_next = HOLD;
                end else if (target > duty) begin
                    state_next = UP;
                    if (tick) begin
                        duty_next = duty + 4'd1;
                        if (duty + 4'd1 == target) begin
                            state_next = HOLD;
                        end
                    end
                end else begin
                    state_next = DOWN;
                    if (tick) begin
                        duty_next = duty - 4'd1;
                        if (duty - 4'd1 == target) begin
                            state_next = HOLD;
                        end
                    end
                end
            end
            BR_UP: begin
                if (!breathe) begin
                    state_next = HOLD;
                end else if (tick) begin
                    if (duty == 4'd15) begin
                        state_next = BR_DOWN;
                        duty_next  = 4'd14;
                    end else begin
                        duty_next = duty + 4'd1;
                    end
                end
            end
            BR_DOWN: begin
                if (!breathe) begin
                    state_next = HOLD;
                end else if (tick) begin
                    if (duty == 4'd0) begin
                        state_next = BR_UP;
                        duty_next  = 4'd1;
                    end else begin
                        duty_next = duty - 4'd1;
                    end
                end
            end
            default: state_next = HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HOLD;
            duty      <= 4'd0;
            step      <= 1'b0;
            at_target <= 1'b1;
        end else begin
            state     <= state_next;
            duty      <= duty_next;
            step      <= (duty_next != duty);
            at_target <= (state_next != BR_UP) && (state_next != BR_DOWN) && (duty_next == target);
        end
    end
endmodule

// File: tb/tb_pwm_duty_slew.sv
// Self-checking bench for pwm_duty_slew: directed scenarios plus random switch activity,
// all compared against a history-based behavioural model of the control rules.

module tb_pwm_duty_slew;
    localparam int STEP = 4;
    localparam int DEB  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic       breathe_n;
    logic [3:0] duty;
    logic       step;
    logic       at_target;

    int n_pass  = 0;
    int n_total = 0;

    pwm_duty_slew #(.STEP_CYCLES(STEP), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .breathe_n (breathe_n),
        .duty      (duty),
        .step      (step),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    // Reference model: a switch value is accepted once the raw samples two or more
    // edges old have been identical for DEB+1 consecutive edges.
    logic [3:0] sw_hist[$];
    logic       br_hist[$];
    int         m_timer;
    int         m_dir;
    int         nd;
    logic [3:0] m_duty;
    logic [3:0] m_target;
    logic       m_breathe;
    logic       m_br_mode;
    logic       m_step;
    logic       m_at;
    bit         m_tick;
    bit         stable;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_hist.delete();
            br_hist.delete();
            for (int i = 0; i < DEB + 3; i++) begin
                sw_hist.push_back(4'hF);
                br_hist.push_back(1'b1);
            end
            m_timer   = 0;
            m_dir     = 0;
            m_duty    = 4'd0;
            m_target  = 4'd0;
            m_breathe = 1'b0;
            m_br_mode = 1'b0;
            m_step    = 1'b0;
            m_at      = 1'b1;
        end else begin
            m_tick  = (m_timer == STEP - 1);
            m_timer = (m_timer + 1) % STEP;
            nd      = int'(m_duty);
            if (m_br_mode && !m_breathe) begin
                m_br_mode = 1'b0;
                m_dir     = 0;
            end else if (m_br_mode) begin
                if (m_tick) begin
                    if (m_dir > 0) begin
                        if (m_duty == 4'd15) begin m_dir = -1; nd = 14; end
                        else nd = nd + 1;
                    end else begin
                        if (m_duty == 4'd0) begin m_dir = 1; nd = 1; end
                        else nd = nd - 1;
                    end
                end
            end else if (m_breathe) begin
                m_br_mode = 1'b1;
                m_dir     = 1;
            end else if (m_target != m_duty) begin
                if (m_dir != 0 && m_tick) nd = nd + ((m_target > m_duty) ? 1 : -1);
                m_dir = (nd == int'(m_target)) ? 0 : ((m_target > m_duty) ? 1 : -1);
            end else begin
                m_dir = 0;
            end
            m_step = (nd != int'(m_duty));
            m_at   = !m_br_mode && (nd == int'(m_target));
            m_duty = 4'(nd);

            sw_hist.push_front(sw);
            void'(sw_hist.pop_back());
            br_hist.push_front(breathe_n);
            void'(br_hist.pop_back());
            stable = 1'b1;
            for (int j = 3; j <= DEB + 2; j++) if (sw_hist[j] != sw_hist[2]) stable = 1'b0;
            if (stable) m_target = ~sw_hist[2];
            stable = 1'b1;
            for (int j = 3; j <= DEB + 2; j++) if (br_hist[j] != br_hist[2]) stable = 1'b0;
            if (stable) m_breathe = ~br_hist[2];
        end
    end

    task automatic test_reset();
        int steps = 0;
        sw = 4'h0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({duty, step, at_target} !== {4'd0, 1'b0, 1'b1})
            $display("FAIL reset_async: duty/step/at_target=%0d/%0b/%0b expected 0/0/1", duty, step, at_target);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 66; c++) begin
            @(negedge clk);
            n_total++;
            if ({duty, step, at_target} !== {m_duty, m_step, m_at})
                $display("FAIL reset_ramp @%0t: duty/step/at_target=%0d/%0b/%0b expected %0d/%0b/%0b",
                         $time, duty, step, at_target, m_duty, m_step, m_at);
            else n_pass++;
            if (step) steps++;
        end
        n_total++;
        if (duty !== 4'd15) $display("FAIL ramp_end_duty: got %0d expected 15", duty);
        else n_pass++;
        n_total++;
        if (steps != 15) $display("FAIL ramp_step_count: got %0d expected 15", steps);
        else n_pass++;
        n_total++;
        if (at_target !== 1'b1) $display("FAIL ramp_at_target: got %0b expected 1", at_target);
        else n_pass++;
    endtask

    task automatic test_debounce();
        int steps = 0;
        sw = 4'hF;
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        sw = 4'b1010;
        repeat (2) @(negedge clk);
        sw = 4'hF;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_total++;
            if (duty !== 4'd0 || step !== 1'b0)
                $display("FAIL bounce_ignored @%0t: duty/step=%0d/%0b expected 0/0", $time, duty, step);
            else n_pass++;
        end
        sw = 4'b1010;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_total++;
            if ({duty, step, at_target} !== {m_duty, m_step, m_at})
                $display("FAIL debounce_ramp @%0t: duty/step/at_target=%0d/%0b/%0b expected %0d/%0b/%0b",
                         $time, duty, step, at_target, m_duty, m_step, m_at);
            else n_pass++;
            if (step) steps++;
        end
        n_total++;
        if (duty !== 4'd5 || steps != 5 || at_target !== 1'b1)
            $display("FAIL debounce_target: duty/steps/at_target=%0d/%0d/%0b expected 5/5/1", duty, steps, at_target);
        else n_pass++;
    endtask

    task automatic test_retarget();
        int seq[$];
        int max_duty = 0;
        bit found = 1'b0;
        for (int c = 0; c < 2 * STEP && !found; c++) begin
            @(negedge clk);
            if (m_timer == STEP - 1) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL retarget_phase: timer phase not found, got 0 expected 1");
        else n_pass++;
        sw = 4'h0;
        repeat (6) @(negedge clk);
        sw = 4'b1100;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_total++;
            if ({duty, step, at_target} !== {m_duty, m_step, m_at})
                $display("FAIL retarget_lockstep @%0t: duty/step/at_target=%0d/%0b/%0b expected %0d/%0b/%0b",
                         $time, duty, step, at_target, m_duty, m_step, m_at);
            else n_pass++;
            if (step) seq.push_back(int'(duty));
            if (int'(duty) > max_duty) max_duty = int'(duty);
        end
        n_total++;
        if (max_duty > 6) $display("FAIL retarget_overshoot: max duty %0d expected <= 6", max_duty);
        else n_pass++;
        n_total++;
        if (seq.size() != 4 || seq[0] != 6 || seq[1] != 5 || seq[2] != 4 || seq[3] != 3)
            $display("FAIL retarget_sequence: got %p expected '{6, 5, 4, 3}", seq);
        else n_pass++;
        n_total++;
        if (duty !== 4'd3 || at_target !== 1'b1)
            $display("FAIL retarget_end: duty/at_target=%0d/%0b expected 3/1", duty, at_target);
        else n_pass++;
    endtask

    task automatic test_breathe();
        int prev = 0;
        int ddir = 0;
        int diff;
        int last_step_c = -1;
        int bad_seq = 0;
        int bad_gap = 0;
        int bad_at = 0;
        int top_times[$];
        sw = 4'hF;
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        breathe_n = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n_total++;
            if ({duty, step, at_target} !== {m_duty, m_step, m_at})
                $display("FAIL breathe_lockstep @%0t: duty/step/at_target=%0d/%0b/%0b expected %0d/%0b/%0b",
                         $time, duty, step, at_target, m_duty, m_step, m_at);
            else n_pass++;
            if (c >= 7 && at_target !== 1'b0) bad_at++;
            if (step) begin
                diff = int'(duty) - prev;
                if (diff != 1 && diff != -1) bad_seq++;
                else if (ddir != 0 && diff != ddir && prev != 0 && prev != 15) bad_seq++;
                if (last_step_c >= 0 && c - last_step_c != STEP) bad_gap++;
                if (duty == 4'd15) top_times.push_back(c);
                ddir = diff;
                prev = int'(duty);
                last_step_c = c;
            end
        end
        n_total++;
        if (bad_seq != 0) $display("FAIL breathe_sequence: %0d bad steps, expected 0", bad_seq);
        else n_pass++;
        n_total++;
        if (bad_gap != 0) $display("FAIL breathe_dwell: %0d irregular step gaps, expected 0", bad_gap);
        else n_pass++;
        n_total++;
        if (bad_at != 0) $display("FAIL breathe_at_target: high in %0d cycles, expected 0", bad_at);
        else n_pass++;
        n_total++;
        if (top_times.size() < 2 || top_times[1] - top_times[0] != 30 * STEP)
            $display("FAIL breathe_period: peaks at %p expected spacing %0d", top_times, 30 * STEP);
        else n_pass++;
    endtask

    task automatic test_breathe_exit();
        int seq[$];
        int last = int'(duty);
        int max_duty = 0;
        bit found = 1'b0;
        sw = 4'b1011;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (step) begin
                if (duty == 4'd11 && last == 10) found = 1'b1;
                last = int'(duty);
            end
        end
        n_total++;
        if (!found) $display("FAIL breathe_exit_wait: duty 11 rising not seen, got 0 expected 1");
        else n_pass++;
        breathe_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            n_total++;
            if ({duty, step, at_target} !== {m_duty, m_step, m_at})
                $display("FAIL breathe_exit_lockstep @%0t: duty/step/at_target=%0d/%0b/%0b expected %0d/%0b/%0b",
                         $time, duty, step, at_target, m_duty, m_step, m_at);
            else n_pass++;
            if (step) seq.push_back(int'(duty));
            if (int'(duty) > max_duty) max_duty = int'(duty);
        end
        n_total++;
        found = (seq.size() == 9);
        for (int i = 0; i < seq.size(); i++) if (seq[i] != 12 - i) found = 1'b0;
        if (!found || max_duty > 12)
            $display("FAIL breathe_exit_sequence: got %p max %0d expected 12 down to 4", seq, max_duty);
        else n_pass++;
        n_total++;
        if (duty !== 4'd4 || at_target !== 1'b1)
            $display("FAIL breathe_exit_end: duty/at_target=%0d/%0b expected 4/1", duty, at_target);
        else n_pass++;
    endtask

    task automatic test_reset_breathe();
        bit found = 1'b0;
        breathe_n = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (duty == 4'd9) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL reset_breathe_wait: duty 9 not seen, got 0 expected 1");
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({duty, step, at_target} !== {4'd0, 1'b0, 1'b1})
            $display("FAIL reset_breathe_async: duty/step/at_target=%0d/%0b/%0b expected 0/0/1", duty, step, at_target);
        else n_pass++;
        breathe_n = 1'b1;
        sw = 4'hF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_total++;
            if ({duty, step, at_target} !== {4'd0, 1'b0, 1'b1})
                $display("FAIL reset_breathe_hold @%0t: duty/step/at_target=%0d/%0b/%0b expected 0/0/1",
                         $time, duty, step, at_target);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int hold;
        for (int i = 0; i < 60; i++) begin
            sw        = 4'($urandom);
            breathe_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            hold      = $urandom_range(1, 40);
            if ($urandom_range(0, 14) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                n_total++;
                if ({duty, step, at_target} !== {m_duty, m_step, m_at})
                    $display("FAIL random_lockstep @%0t: duty/step/at_target=%0d/%0b/%0b expected %0d/%0b/%0b",
                             $time, duty, step, at_target, m_duty, m_step, m_at);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        sw        = 4'hF;
        breathe_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_debounce();
        test_retarget();
        test_breathe();
        test_breathe_exit();
        test_reset_breathe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
